// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU load/store port and a DMA port.
// CPU has default priority; DMA wins on starvation or while a locked burst is within its beat budget.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [1:0]        cpu_size,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic [1:0]        dma_size,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  cpu_stall_cnt
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [SW-1:0] S_MAX = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] B_MAX = BW'(MAX_BURST);

  typedef enum logic {OWN_CPU, OWN_DMA} owner_e;

  owner_e            owner_q, owner_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              dma_win;

  assign cpu_rdata     = mem_rdata;
  assign dma_rdata     = mem_rdata;
  assign cpu_stall_cnt = stall_q;

  always_comb begin
    dma_win   = dma_req & (~cpu_req | (starve_q == S_MAX) |
                           ((owner_q == OWN_DMA) & dma_lock & (burst_q < B_MAX)));
    dma_gnt   = rst_n & dma_win;
    cpu_gnt   = rst_n & cpu_req & ~dma_win;
    cpu_stall = rst_n & cpu_req & ~cpu_gnt;
    mem_addr  = dma_gnt ? dma_addr : cpu_addr;
    mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
    mem_size  = dma_gnt ? dma_size : cpu_size;
    mem_we    = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);
    mem_re    = (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);
    owner_d   = dma_gnt ? OWN_DMA : OWN_CPU;
    starve_d  = (dma_req & ~dma_gnt) ? ((starve_q == S_MAX) ? S_MAX : starve_q + 1'b1) : '0;
    burst_d   = dma_gnt ? ((owner_q == OWN_DMA) ? ((burst_q == B_MAX) ? B_MAX : burst_q + 1'b1)
                                                : BW'(1)) : '0;
    stall_d   = stall_q + CNT_W'(cpu_stall & ~&stall_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= OWN_CPU;
      starve_q <= '0;
      burst_q  <= '0;
      stall_q  <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
      burst_q  <= burst_d;
      stall_q  <= stall_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table plus hand-written multi-cycle sequences for dmem_arbiter.
module tb_dmem_arbiter;
  localparam logic O = 1'b0, I = 1'b1;
  localparam logic [1:0] CS = 2'b10, DS = 2'b00;

  typedef struct packed {
    logic cr, cw; logic [31:0] ca, cd;
    logic dr, dw, dl; logic [31:0] da, dd;
    logic e_cg, e_dg, e_st, e_we, e_re; logic [1:0] e_sz; logic [31:0] e_addr, e_wd;
    logic rd_chk; logic [31:0] e_rd; logic [15:0] e_cnt;
  } vec_t;

  logic        clk, rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [1:0]  cpu_size, dma_size, mem_size, mem_size4;
  logic        cpu_gnt, cpu_stall, dma_gnt, mem_we, mem_re;
  logic        cpu_gnt4, cpu_stall4, dma_gnt4, mem_we4, mem_re4;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] cpu_rdata4, dma_rdata4, mem_addr4, mem_wdata4;
  logic [15:0] cpu_stall_cnt;
  logic [3:0]  cnt4;
  logic [31:0] mem [0:63];
  int n_vec = 0, n_err = 0;
  vec_t tbl [11];

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_size(cpu_size), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_size(dma_size), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .cpu_stall_cnt(cpu_stall_cnt)
  );

  dmem_arbiter #(.CNT_W(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_size(cpu_size), .cpu_gnt(cpu_gnt4), .cpu_stall(cpu_stall4), .cpu_rdata(cpu_rdata4),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_size(dma_size), .dma_gnt(dma_gnt4), .dma_rdata(dma_rdata4),
    .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_size(mem_size4), .mem_we(mem_we4),
    .mem_re(mem_re4), .mem_rdata(mem_rdata), .cpu_stall_cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, 32'(act), 32'(exp));
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 32'h44; cpu_wdata = 32'h55;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = 32'h99; dma_wdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    cpu_size = CS; dma_size = DS;
    tbl[0]  = '{O,O,32'h44,32'h55, O,O,O,32'h99,32'h0,        O,O,O,O,O,CS,32'h44,32'h55,       O,32'h0,16'd0};
    tbl[1]  = '{I,O,32'h10,32'h0,  O,O,O,32'h99,32'h0,        I,O,O,O,I,CS,32'h10,32'h0,        O,32'h0,16'd0};
    tbl[2]  = '{O,O,32'h44,32'h55, I,I,O,32'h20,32'hDEADBEEF, O,I,O,I,O,DS,32'h20,32'hDEADBEEF, O,32'h0,16'd0};
    tbl[3]  = '{I,O,32'h20,32'h0,  O,O,O,32'h99,32'h0,        I,O,O,O,I,CS,32'h20,32'h0,        I,32'hDEADBEEF,16'd0};
    tbl[4]  = '{I,I,32'h30,32'h12345678, O,O,O,32'h99,32'h0,  I,O,O,I,O,CS,32'h30,32'h12345678, O,32'h0,16'd0};
    tbl[5]  = '{I,O,32'h30,32'h0,  I,O,O,32'h40,32'h0,        I,O,O,O,I,CS,32'h30,32'h0,        I,32'h12345678,16'd0};
    tbl[6]  = '{O,O,32'h44,32'h55, I,O,O,32'h30,32'hAAAA0000, O,I,O,O,I,DS,32'h30,32'hAAAA0000, I,32'h12345678,16'd0};
    tbl[7]  = '{I,O,32'h10,32'h0,  I,I,I,32'h34,32'hCAFEF00D, O,I,I,I,O,DS,32'h34,32'hCAFEF00D, O,32'h0,16'd0};
    tbl[8]  = '{I,I,32'h38,32'h0BADC0DE, I,O,O,32'h34,32'h0,  I,O,O,I,O,CS,32'h38,32'h0BADC0DE, O,32'h0,16'd1};
    tbl[9]  = '{O,O,32'h44,32'h55, I,O,O,32'h34,32'h0,        O,I,O,O,I,DS,32'h34,32'h0,        I,32'hCAFEF00D,16'd1};
    tbl[10] = '{O,O,32'h44,32'h55, O,O,O,32'h99,32'h0,        O,O,O,O,O,CS,32'h44,32'h55,       O,32'h0,16'd1};

    do_reset();
    chk("reset cnt", 32'(cpu_stall_cnt), 32'h0);
    for (int i = 0; i < 11; i++) begin
      cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = tbl[i].ca; cpu_wdata = tbl[i].cd;
      dma_req = tbl[i].dr; dma_we = tbl[i].dw; dma_lock = tbl[i].dl;
      dma_addr = tbl[i].da; dma_wdata = tbl[i].dd;
      @(negedge clk);
      chk1($sformatf("v%0d cpu_gnt", i), cpu_gnt, tbl[i].e_cg);
      chk1($sformatf("v%0d dma_gnt", i), dma_gnt, tbl[i].e_dg);
      chk1($sformatf("v%0d cpu_stall", i), cpu_stall, tbl[i].e_st);
      chk1($sformatf("v%0d mem_we", i), mem_we, tbl[i].e_we);
      chk1($sformatf("v%0d mem_re", i), mem_re, tbl[i].e_re);
      chk($sformatf("v%0d mem_size", i), 32'(mem_size), 32'(tbl[i].e_sz));
      chk($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, tbl[i].e_wd);
      chk($sformatf("v%0d stall_cnt", i), 32'(cpu_stall_cnt), 32'(tbl[i].e_cnt));
      if (tbl[i].rd_chk) begin
        chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, tbl[i].e_rd);
        chk($sformatf("v%0d dma_rdata", i), dma_rdata, tbl[i].e_rd);
      end
      next_cyc();
    end

    // Anti-starvation: CPU x4 then forced DMA, repeating
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cpu_req = 1; dma_req = 1; dma_lock = 0;
      @(negedge clk);
      chk1($sformatf("starve k%0d cpu_gnt", k), cpu_gnt, k % 5 != 4);
      chk1($sformatf("starve k%0d dma_gnt", k), dma_gnt, k % 5 == 4);
      chk($sformatf("starve k%0d cnt", k), 32'(cpu_stall_cnt), 32'(k / 5));
      next_cyc();
    end
    idle_inputs();
    @(negedge clk);
    chk("starve final cnt", 32'(cpu_stall_cnt), 32'd2);
    next_cyc();

    // Locked burst capped at 8 beats, then CPU gets a slot
    do_reset();
    for (int j = 0; j < 10; j++) begin
      cpu_req = (j > 0); dma_req = 1; dma_lock = 1;
      @(negedge clk);
      chk1($sformatf("burst j%0d dma_gnt", j), dma_gnt, j < 8);
      chk1($sformatf("burst j%0d cpu_gnt", j), cpu_gnt, j >= 8);
      chk($sformatf("burst j%0d cnt", j), 32'(cpu_stall_cnt), 32'((j > 8) ? 7 : (j > 0 ? j - 1 : 0)));
      next_cyc();
    end

    // Async reset mid-burst
    do_reset();
    for (int j = 0; j < 4; j++) begin
      cpu_req = (j > 0); cpu_we = 0; cpu_addr = 32'h50;
      dma_req = 1; dma_we = 1; dma_lock = 1; dma_addr = 32'h50; dma_wdata = 32'(j + 1);
      @(negedge clk);
      chk1($sformatf("rst beat%0d dma_gnt", j), dma_gnt, 1'b1);
      if (j < 3) next_cyc();
    end
    chk("rst pre cnt", 32'(cpu_stall_cnt), 32'd2);
    rst_n = 0; #1;
    chk1("rst dma_gnt", dma_gnt, 1'b0);
    chk1("rst cpu_gnt", cpu_gnt, 1'b0);
    chk1("rst mem_we", mem_we, 1'b0);
    chk1("rst mem_re", mem_re, 1'b0);
    chk1("rst cpu_stall", cpu_stall, 1'b0);
    chk("rst cnt", 32'(cpu_stall_cnt), 32'd0);
    next_cyc();
    chk1("rst held mem_we", mem_we, 1'b0);
    @(negedge clk) rst_n = 1; #1;
    chk1("post cpu_gnt", cpu_gnt, 1'b1);
    chk1("post dma_gnt", dma_gnt, 1'b0);
    chk("post cnt", 32'(cpu_stall_cnt), 32'd0);
    chk("post rdata", cpu_rdata, 32'd3);
    next_cyc();
    @(negedge clk);
    chk1("post2 cpu_gnt", cpu_gnt, 1'b1);
    chk("post2 cnt", 32'(cpu_stall_cnt), 32'd0);
    next_cyc();

    // Saturation of the 4-bit stall counter over three locked bursts
    do_reset();
    for (int s = 0; s < 3; s++) begin
      cpu_req = 0; cpu_we = 0; dma_req = 1; dma_we = 0; dma_lock = 1;
      @(negedge clk);
      chk1($sformatf("sat s%0d dma_gnt", s), dma_gnt, 1'b1);
      chk($sformatf("sat s%0d cnt16", s), 32'(cpu_stall_cnt), 32'(7 * s));
      chk($sformatf("sat s%0d cnt4", s), 32'(cnt4), 32'((7 * s > 15) ? 15 : 7 * s));
      next_cyc();
      cpu_req = 1;
      repeat (7) next_cyc();
      dma_req = 0;
      @(negedge clk);
      chk1($sformatf("sat s%0d cpu_gnt", s), cpu_gnt, 1'b1);
      next_cyc();
    end
    idle_inputs();
    @(negedge clk);
    chk("sat final cnt16", 32'(cpu_stall_cnt), 32'd21);
    chk("sat final cnt4", 32'(cnt4), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
